dm_access_unit: RTL
===================

// Module: dm_access_unit
// PURPOSE
//  Load/store sequencer in front of the 1024x32 data memory, driven by the CPU execute stage.
//  Converts byte/half/word loads and stores into word-only memory accesses.
//  Sub-word stores use a read-modify-write.
//  Returns sign- or zero-extended load data through a req/ready/done handshake.
// PARAMETERS
//  ADDR_W   10   data-memory word-address width (1024 words); drives dm_addr[ADDR_W+1:2]
// PORTS
//  clk        in   1         clock; all state updates on posedge
//  rst_n      in   1         asynchronous active-low reset
//  req        in   1         access request; sampled only when ready=1
//  ready      out  1         unit idle, can accept req
//  is_store   in   1         1=store, 0=load
//  size       in   2         00 byte, 01 half, 10 word, 11 treated as word
//  sign_ext   in   1         loads: 1=sign-extend, 0=zero-extend
//  addr       in   32        byte address; bits [ADDR_W+1:0] used
//  wdata      in   32        store data, right-aligned
//  rdata      out  32        extended load data, valid while done=1
//  done       out  1         one-cycle completion pulse
//  err        out  1         misalignment flag with done (see CONFIGURATION)
//  dm_addr    out  ADDR_W    word address to data memory
//  dm_din     out  32        write data to data memory
//  dm_we      out  1         write enable; memory writes on negedge clk
//  dm_dout    in   32        asynchronous read data from memory
// BEHAVIOUR
//  - Reset, asynchronous: state=IDLE; ready=1; done=0; err=0; rdata=0; dm_we=0.
//    Reset during RD/WR cancels the access. No write occurs, because dm_we is decoded from state.
//  - FSM states: IDLE, RD, WR, DONE.
//    IDLE: on req, latch is_store/size/sign_ext/addr/wdata.
//      load                      -> RD
//      word store                -> WR
//      sub-word store            -> RD
//    RD: capture dm_dout into hold register.
//      load                      -> DONE
//      store                     -> WR
//    WR: dm_we=1 for exactly this cycle; dm_din = merged word -> DONE.
//    DONE: done=1, ready=0 -> IDLE.
//  - ready=1 only in IDLE. req while ready=0 is ignored, not queued.
//    Inputs other than req are don't-care outside the acceptance cycle.
//  - Latency from accept cycle T: load done at T+2, word store at T+2, sub-word store at T+3.
//  - dm_addr = latched addr[ADDR_W+1:2] in every non-IDLE state; in IDLE it follows the live addr.
//  - Lanes are little-endian: byte k = bits[8k+7:8k], selected by addr[1:0]; half h = bits[16h+15:16h], selected by addr[1].
//  - Load extract: selected lane, extended to 32 bits per sign_ext. Word loads pass through unchanged.
//  - Store merge: only the selected lane is replaced by wdata[7:0] or wdata[15:0]; other lanes keep the RD-captured value.
//  - Address arithmetic: none. Addresses beyond 4 KiB alias by truncation.
// CONFIGURATION
//  DM_ALIGN_CHECK_EN defined:
//    - Misaligned requests are half with addr[0]=1, or word with addr[1:0]!=0.
//    - They go IDLE->DONE, err=1 with done, rdata=0, dm_we never asserted.
//  DM_ALIGN_CHECK_EN undefined:
//    - err tied 0.
//    - Half ignores addr[0]; word ignores addr[1:0] (forced alignment).
// STRUCTURE
//  - Shared defines file (dm_defs.vh): size encodings SZ_BYTE/SZ_HALF/SZ_WORD, FSM state encodings, DM_WORDS=1024.
//  - Sub-module dm_lane_mux (combinational): extract+extend for loads, merge for stores. Instanced once.
//  - FSM and latches live in dm_access_unit.
// TESTING
//  1. Reset: rst_n=0 mid-WR -> dm_we drops at once; memory word unchanged; ready=1, done=0, rdata=0.
//  2. Word store then load: store 0xDEADBEEF @0x010 -> dm_we only in cycle T+1, done T+2.
//     Load word @0x010 -> rdata=0xDEADBEEF at T+2.
//  3. Byte RMW: mem[0x020]=0x11223344; store byte 0xAA @0x021 -> mem=0x1122AA44.
//     Checks: done at T+3; dm_we high for exactly 1 cycle.
//  4. Load extend: mem[0x030]=0x80FF7F01.
//     lb @0x033 sign -> 0xFFFFFF80; lbu @0x033 -> 0x00000080.
//     lh @0x032 sign -> 0xFFFF80FF; lhu @0x030 -> 0x00007F01.
//  5. Handshake: req held high during RD/WR/DONE -> ignored; exactly one access per accept.
//     Back-to-back accept resumes the cycle after DONE.
//  6. DM_ALIGN_CHECK_EN: word store @0x042 -> done+err at T+1, memory untouched.
//     Without the macro: the same store writes mem[0x040].

Source files
------------

// File: rtl/dm_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states, memory depth.
package dm_access_unit_pkg;

    localparam int DM_WORDS = 1024;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } dm_state_t;

endpackage

// File: rtl/dm_access_unit_lane_mux.sv
// Little-endian lane selection: extract+extend for loads, single-lane merge for stores.
// Purely combinational; size 11 behaves as a word.
module dm_lane_mux
    import dm_access_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rword_i[{lane_i, 3'b000} +: 8];
        half_sel  = rword_i[{lane_i[1], 4'b0000} +: 16];
        ld_data_o = rword_i;
        st_data_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                ld_data_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
                st_data_o = rword_i;
                st_data_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                // addr[0] is ignored here; misalignment is handled (or forgiven) upstream
                ld_data_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
                st_data_o = rword_i;
                st_data_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                ld_data_o = rword_i;
                st_data_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Byte/half/word load-store sequencer over a word-only memory; sub-word stores do read-modify-write.
// Done at T+2 (load, word store) or T+3 (sub-word store); no queueing, req ignored unless ready. Option: DM_ALIGN_CHECK_EN.
module dm_access_unit
    import dm_access_unit_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ready,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    dm_state_t          state_q, state_d;
    logic               st_q;
    logic [1:0]         size_q;
    logic               sext_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        hold_q;
    logic               mis_q;
    logic               mis;
    logic [31:0]        ld_data;
    logic [31:0]        st_data;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef DM_ALIGN_CHECK_EN
    assign mis = ((size == SZ_HALF) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (mis)
                        state_d = ST_DONE;
                    else if (is_store && size[1])
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD:   state_d = st_q ? ST_WR : ST_DONE;
            ST_WR:   state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            st_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req) begin
                st_q    <= is_store;
                size_q  <= size;
                sext_q  <= sign_ext;
                addr_q  <= addr[ADDR_W+1:0];
                wdata_q <= wdata;
                mis_q   <= mis;
            end
            if (state_q == ST_RD)
                hold_q <= dm_dout;
        end
    end

    dm_lane_mux u_lane_mux (
        .size_i     (size_q),
        .sign_ext_i (sext_q),
        .lane_i     (addr_q[1:0]),
        .rword_i    (hold_q),
        .wdata_i    (wdata_q),
        .ld_data_o  (ld_data),
        .st_data_o  (st_data)
    );

    // Write enable is a pure state decode so an async reset in WR kills the write immediately.
    assign dm_we   = (state_q == ST_WR);
    assign dm_din  = st_data;
    assign dm_addr = (state_q == ST_IDLE) ? addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
    assign ready   = (state_q == ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign rdata   = (done && !st_q && !mis_q) ? ld_data : 32'h0;

`ifdef DM_ALIGN_CHECK_EN
    assign err = done && mis_q;
`else
    assign err = 1'b0;
`endif

endmodule
